partitioned_cacheline: RTL

Single-set, way-partitioned cache line that answers the OS/user request interface used by the team's noninterference harnesses. An OS request installs a way-partition mask (the policy hitmap). User requests look up and fill only within that mask, using MRU-bit replacement. All state changes are confined to ways inside the active policy, so activity in one domain cannot perturb another domain's ways. Internal state is exported on observation ports for invariant checking.

---
 rtl/partitioned_cacheline_if.sv | 27 ++
 rtl/partitioned_cacheline.sv | 107 ++++++++++
 2 files changed

// File: rtl/partitioned_cacheline_if.sv
// Request/observation bundle for the partitioned cache line.
// The master side issues OS and user requests and watches the exported state.
// The slave side is the cache line itself.
interface partitioned_cacheline_if #(
  parameter int NUM_WAYS   = 8,
  parameter int ADDR_WIDTH = 8
);
  logic                             os_req;
  logic [NUM_WAYS-1:0]              hitmap;
  logic                             user_req;
  logic [ADDR_WIDTH-1:0]            addr;
  logic                             hit;
  logic [NUM_WAYS-1:0]              policy_hitmap_o;
  logic [NUM_WAYS-1:0]              metadata_o;
  logic [ADDR_WIDTH*NUM_WAYS-1:0]   all_tags_o;
  logic [NUM_WAYS-1:0]              all_valid_o;

  modport master (
    output os_req, hitmap, user_req, addr,
    input  hit, policy_hitmap_o, metadata_o, all_tags_o, all_valid_o
  );

  modport slave (
    input  os_req, hitmap, user_req, addr,
    output hit, policy_hitmap_o, metadata_o, all_tags_o, all_valid_o
  );
endinterface

// File: rtl/partitioned_cacheline.sv
// Single-set, way-partitioned cache line with MRU-bit replacement.
// An OS request installs the way-partition mask. User requests look up and
// fill only inside that mask, so one domain never disturbs another's ways.
// All state is exported directly from registers for invariant checking.
module partitioned_cacheline #(
  parameter int NUM_WAYS   = 8,
  parameter int ADDR_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  partitioned_cacheline_if.slave bus
);

  localparam int IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  logic [NUM_WAYS-1:0]   valid_q;
  logic [ADDR_WIDTH-1:0] tag_q [NUM_WAYS];
  logic [NUM_WAYS-1:0]   mru_q;
  logic [NUM_WAYS-1:0]   policy_q;
  logic                  hit_q;

  logic [NUM_WAYS-1:0]   match;
  logic [NUM_WAYS-1:0]   free_ways;
  logic [NUM_WAYS-1:0]   cold_ways;
  logic                  any_match;
  logic [IDX_W-1:0]      way_sel;
  logic [NUM_WAYS-1:0]   sel_onehot;
  logic [NUM_WAYS-1:0]   mru_set;
  logic [NUM_WAYS-1:0]   mru_next;
  logic [ADDR_WIDTH*NUM_WAYS-1:0] tags_flat;

  // Index of the lowest set bit; callers guarantee at least one bit is set.
  function automatic logic [IDX_W-1:0] lowest_index(input logic [NUM_WAYS-1:0] vec);
    lowest_index = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (vec[i]) lowest_index = IDX_W'(i);
    end
  endfunction

  // Tag compare, restricted to valid ways inside the active partition.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      match[i] = policy_q[i] & valid_q[i] & (tag_q[i] == bus.addr);
    end
  end

  // Pick the hit way, or on a miss the victim: invalid, then non-MRU, then
  // lowest policy way. The policy mask is never zero, so a way always exists.
  always_comb begin
    free_ways = policy_q & ~valid_q;
    cold_ways = policy_q & ~mru_q;
    any_match = |match;
    if (any_match)       way_sel = lowest_index(match);
    else if (|free_ways) way_sel = lowest_index(free_ways);
    else if (|cold_ways) way_sel = lowest_index(cold_ways);
    else                 way_sel = lowest_index(policy_q);
  end

  // MRU update: mark the selected way; once every policy way is marked,
  // clear the others inside the policy. Bits outside the policy pass through.
  always_comb begin
    sel_onehot = '0;
    sel_onehot[way_sel] = 1'b1;
    mru_set = mru_q | sel_onehot;
    if ((mru_set & policy_q) == policy_q) mru_next = (mru_set & ~policy_q) | sel_onehot;
    else                                  mru_next = mru_set;
  end

  // Flatten the tag array for the observation port.
  always_comb begin
    tags_flat = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      tags_flat[ADDR_WIDTH*i +: ADDR_WIDTH] = tag_q[i];
    end
  end

  // State update: OS request has priority over a user request; idle clears hit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= '0;
      mru_q    <= '0;
      policy_q <= '1;
      hit_q    <= 1'b0;
      for (int i = 0; i < NUM_WAYS; i++) tag_q[i] <= '0;
    end else if (bus.os_req) begin
      if (|bus.hitmap) policy_q <= bus.hitmap;
      hit_q <= 1'b0;
    end else if (bus.user_req) begin
      hit_q <= any_match;
      if (!any_match) begin
        valid_q[way_sel] <= 1'b1;
        tag_q[way_sel]   <= bus.addr;
      end
      mru_q <= mru_next;
    end else begin
      hit_q <= 1'b0;
    end
  end

  assign bus.hit             = hit_q;
  assign bus.policy_hitmap_o = policy_q;
  assign bus.metadata_o      = mru_q;
  assign bus.all_valid_o     = valid_q;
  assign bus.all_tags_o      = tags_flat;

endmodule
